// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state encoding for the regfile_sb register file.
// Optional build macro used by this block: REGFILE_ZERO_REG_EN.
package regfile_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by mark, cleared by writeback
// or by the clear sequencer; raises stall when either read port hits a pending entry.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              mark_en,
   input  logic [ADDR_W-1:0] mark_addr,
   input  logic              clr_active,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   output logic              stall
);

   localparam int NREGS = 2**ADDR_W;

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_next;

   // Mark is applied after the writeback clear so a re-issued writer stays outstanding.
   always_comb begin
      pending_next = pending;
      if (clr_active) begin
         pending_next[clr_addr] = 1'b0;
      end else begin
         if (wr_en) pending_next[wr_addr] = 1'b0;
         if (mark_en) pending_next[mark_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pending_next;
   end

   assign stall = clr_active | pending[src] | pending[dst];

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file: two async read ports with write forwarding, one write
// port, pending-write scoreboard and a one-entry-per-cycle clear sequencer.
// REGFILE_ZERO_REG_EN makes register 0 a hardwired zero.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   output logic [DATA_W-1:0] Rsrc,
   output logic [DATA_W-1:0] Rdst,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] WD,
   input  logic              mark,
   input  logic [ADDR_W-1:0] mark_addr,
   output logic              stall,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam int NREGS = 2**ADDR_W;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] regs [NREGS];
   logic              idle;
   logic              clr_active;
   logic              last_entry;
   logic              we_eff;
   logic              mark_eff;

   assign idle       = (state == ST_IDLE);
   assign last_entry = (cnt == ADDR_W'(NREGS - 1));

   // With the zero register, writes and marks to address 0 vanish here, so the
   // array, forwarding and scoreboard never see them.
`ifdef REGFILE_ZERO_REG_EN
   assign we_eff   = WE && idle && (WA != '0);
   assign mark_eff = mark && idle && (mark_addr != '0);
`else
   assign we_eff   = WE && idle;
   assign mark_eff = mark && idle;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (clr_req) state_next = ST_CLEAR;
         ST_CLEAR: if (last_entry) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      clr_active = 1'b0;
      if (state == ST_CLEAR) clr_active = 1'b1;
   end

   assign clr_busy = clr_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             cnt <= '0;
      else if (clr_active) cnt <= cnt + 1'b1;
      else                 cnt <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (clr_active) begin
         regs[cnt] <= '0;
      end else if (we_eff) begin
         regs[WA] <= WD;
      end
   end

   // Forwarding is gated by we_eff, so it is off during CLEAR and for address 0 when hardwired.
   assign Rsrc = (we_eff && (WA == src)) ? WD : regs[src];
   assign Rdst = (we_eff && (WA == dst)) ? WD : regs[dst];

   regfile_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (we_eff),
      .wr_addr    (WA),
      .mark_en    (mark_eff),
      .mark_addr  (mark_addr),
      .clr_active (clr_active),
      .clr_addr   (cnt),
      .src        (src),
      .dst        (dst),
      .stall      (stall)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic against a
// behavioural model; a second 32-bit/32-entry instance covers the parameter sweep.
module tb_regfile_sb;

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  src, dst, WA, mark_addr;
   logic [15:0] WD, Rsrc, Rdst;
   logic        WE, mark, clr_req, stall, clr_busy;

   logic [4:0]  w_src, w_dst, w_WA, w_mark_addr;
   logic [31:0] w_WD, w_Rsrc, w_Rdst;
   logic        w_WE, w_mark, w_clr_req, w_stall, w_clr_busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   logic [15:0] m_regs [16];
   bit          m_pend [16];
   bit          m_busy;
   int          m_cidx;

   regfile_sb u_dut (
      .clk(clk), .rst(rst), .src(src), .dst(dst), .Rsrc(Rsrc), .Rdst(Rdst),
      .WE(WE), .WA(WA), .WD(WD), .mark(mark), .mark_addr(mark_addr),
      .stall(stall), .clr_req(clr_req), .clr_busy(clr_busy)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5)) u_wide (
      .clk(clk), .rst(rst), .src(w_src), .dst(w_dst), .Rsrc(w_Rsrc), .Rdst(w_Rdst),
      .WE(w_WE), .WA(w_WA), .WD(w_WD), .mark(w_mark), .mark_addr(w_mark_addr),
      .stall(w_stall), .clr_req(w_clr_req), .clr_busy(w_clr_busy)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model
   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_cidx = 0;
   endfunction

   function automatic logic [15:0] exp_read(input logic [3:0] a);
      if (ZERO_EN && a == 4'd0) return 16'h0;
      if (!m_busy && WE && WA == a) return WD;
      return m_regs[a];
   endfunction

   function automatic logic exp_stall();
      return m_busy || m_pend[src] || m_pend[dst];
   endfunction

   function automatic void model_edge();
      if (m_busy) begin
         m_regs[m_cidx] = '0;
         m_pend[m_cidx] = 1'b0;
         m_cidx++;
         if (m_cidx == 16) m_busy = 1'b0;
      end else begin
         if (WE && !(ZERO_EN && WA == 4'd0)) begin
            m_regs[WA] = WD;
            m_pend[WA] = 1'b0;
         end
         if (mark && !(ZERO_EN && mark_addr == 4'd0)) m_pend[mark_addr] = 1'b1;
         if (clr_req) begin
            m_busy = 1'b1;
            m_cidx = 0;
         end
      end
   endfunction

   // Driver tasks
   task automatic step();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      WE = 0; WA = 0; WD = 0; mark = 0; mark_addr = 0; clr_req = 0; src = 0; dst = 0;
      w_WE = 0; w_WA = 0; w_WD = 0; w_mark = 0; w_mark_addr = 0; w_clr_req = 0;
      w_src = 0; w_dst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      WE = 1; WA = 4'd3; WD = 16'h00A5; src = 4'd3; dst = 4'd4;
      #2;
      n_checks++; if (Rsrc !== 16'h00A5) $display("FAIL reset_fwd Rsrc=%h exp=%h", Rsrc, 16'h00A5); else n_pass++;
      n_checks++; if (Rdst !== 16'h0) $display("FAIL reset_rdst Rdst=%h exp=0", Rdst); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall stall=%b exp=0", stall); else n_pass++;
      n_checks++; if (clr_busy !== 1'b0) $display("FAIL reset_busy clr_busy=%b exp=0", clr_busy); else n_pass++;
      step();
      step();
      rst = 1'b0;
      WE = 0;
      #1;
      n_checks++; if (Rsrc !== 16'h0) $display("FAIL reset_array Rsrc=%h exp=0", Rsrc); else n_pass++;
   endtask

   task automatic test_write_read();
      WE = 1; WA = 4'd3; WD = 16'h00A5; src = 4'd3; dst = 4'd4;
      #1;
      n_checks++; if (Rsrc !== 16'h00A5) $display("FAIL wr_fwd Rsrc=%h exp=%h", Rsrc, 16'h00A5); else n_pass++;
      step();
      WE = 0;
      #1;
      n_checks++; if (Rsrc !== 16'h00A5) $display("FAIL wr_array Rsrc=%h exp=%h", Rsrc, 16'h00A5); else n_pass++;
      n_checks++; if (Rdst !== 16'h0) $display("FAIL wr_other Rdst=%h exp=0", Rdst); else n_pass++;
   endtask

   task automatic test_scoreboard();
      mark = 1; mark_addr = 4'd5; src = 4'd5; dst = 4'd1;
      #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL sb_premark stall=%b exp=0", stall); else n_pass++;
      step();
      mark = 0;
      #1;
      n_checks++; if (stall !== 1'b1) $display("FAIL sb_mark stall=%b exp=1", stall); else n_pass++;
      WE = 1; WA = 4'd5; WD = 16'($urandom);
      #1;
      n_checks++; if (stall !== 1'b1) $display("FAIL sb_fwd_stall stall=%b exp=1", stall); else n_pass++;
      step();
      WE = 0;
      #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL sb_cleared stall=%b exp=0", stall); else n_pass++;
      mark = 1; mark_addr = 4'd7; WE = 1; WA = 4'd7; WD = 16'h0777; src = 4'd7;
      step();
      mark = 0; WE = 0;
      #1;
      n_checks++; if (stall !== 1'b1) $display("FAIL sb_mark_wins stall=%b exp=1", stall); else n_pass++;
      WE = 1; WA = 4'd7;
      step();
      WE = 0;
      #1;
      n_checks++; if (stall !== exp_stall()) $display("FAIL sb_release stall=%b exp=%b", stall, exp_stall()); else n_pass++;
   endtask

   task automatic test_clear();
      for (int i = 0; i < 16; i++) begin
         WE = 1; WA = 4'(i); WD = 16'(i + 1);
         step();
      end
      WE = 0;
      mark = 1; mark_addr = 4'd9;
      step();
      mark = 0; src = 4'd9; dst = 4'd1;
      #1;
      n_checks++; if (stall !== 1'b1) $display("FAIL clr_premark stall=%b exp=1", stall); else n_pass++;
      n_checks++; if (Rdst !== 16'd2) $display("FAIL clr_fill Rdst=%h exp=2", Rdst); else n_pass++;
      clr_req = 1;
      step();
      clr_req = 0;
      for (int c = 0; c < 16; c++) begin
         if (c == 5) begin
            WE = 1; WA = 4'd2; WD = 16'hFFFF; src = 4'd2;
         end
         #1;
         n_checks++; if (clr_busy !== 1'b1) $display("FAIL clr_busy_c%0d clr_busy=%b exp=1", c, clr_busy); else n_pass++;
         n_checks++; if (stall !== 1'b1) $display("FAIL clr_stall_c%0d stall=%b exp=1", c, stall); else n_pass++;
         if (c == 5) begin
            n_checks++; if (Rsrc !== exp_read(4'd2)) $display("FAIL clr_nofwd Rsrc=%h exp=%h", Rsrc, exp_read(4'd2)); else n_pass++;
         end
         step();
         WE = 0;
      end
      #1;
      n_checks++; if (clr_busy !== 1'b0) $display("FAIL clr_done clr_busy=%b exp=0", clr_busy); else n_pass++;
      for (int a = 0; a < 16; a++) begin
         src = 4'(a); dst = 4'(15 - a);
         #1;
         n_checks++; if (Rsrc !== 16'h0) $display("FAIL clr_zero_%0d Rsrc=%h exp=0", a, Rsrc); else n_pass++;
         n_checks++; if (stall !== 1'b0) $display("FAIL clr_nostall_%0d stall=%b exp=0", a, stall); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_clear();
      for (int i = 1; i < 16; i += 3) begin
         WE = 1; WA = 4'(i); WD = 16'($urandom_range(1, 16'hFFFF));
         step();
      end
      WE = 0;
      mark = 1; mark_addr = 4'd12;
      step();
      mark = 0;
      clr_req = 1;
      step();
      clr_req = 0;
      for (int c = 0; c < 6; c++) step();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++; if (clr_busy !== 1'b0) $display("FAIL rmc_busy clr_busy=%b exp=0", clr_busy); else n_pass++;
      for (int a = 0; a < 16; a++) begin
         src = 4'(a); dst = 4'd12;
         #1;
         n_checks++; if (Rsrc !== 16'h0) $display("FAIL rmc_zero_%0d Rsrc=%h exp=0", a, Rsrc); else n_pass++;
      end
      n_checks++; if (stall !== 1'b0) $display("FAIL rmc_stall stall=%b exp=0", stall); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      WE = 1; WA = 4'd6; WD = 16'h6B6B; src = 4'd6;
      step();
      WE = 0;
      #1;
      n_checks++; if (Rsrc !== 16'h6B6B) $display("FAIL rmc_write Rsrc=%h exp=%h", Rsrc, 16'h6B6B); else n_pass++;
      n_checks++; if (clr_busy !== 1'b0) $display("FAIL rmc_idle clr_busy=%b exp=0", clr_busy); else n_pass++;
   endtask

   task automatic test_zero_reg();
      logic [15:0] exp_z;
      exp_z = ZERO_EN ? 16'h0 : 16'h1234;
      WE = 1; WA = 4'd0; WD = 16'h1234; src = 4'd0; dst = 4'd1;
      #1;
      n_checks++; if (Rsrc !== exp_z) $display("FAIL zero_fwd Rsrc=%h exp=%h", Rsrc, exp_z); else n_pass++;
      step();
      WE = 0;
      #1;
      n_checks++; if (Rsrc !== exp_z) $display("FAIL zero_array Rsrc=%h exp=%h", Rsrc, exp_z); else n_pass++;
      mark = 1; mark_addr = 4'd0;
      step();
      mark = 0;
      #1;
      n_checks++; if (stall !== !ZERO_EN) $display("FAIL zero_stall stall=%b exp=%b", stall, !ZERO_EN); else n_pass++;
      WE = 1; WA = 4'd0;
      step();
      WE = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         WE = 1'($urandom); WA = 4'($urandom); WD = 16'($urandom);
         mark = ($urandom_range(0, 3) == 0); mark_addr = 4'($urandom);
         src = 4'($urandom); dst = 4'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            mark_addr = WA;
            src = WA;
         end
         clr_req = ($urandom_range(0, 39) == 0);
         #1;
         n_checks++; if (Rsrc !== exp_read(src)) $display("FAIL rnd_rsrc n=%0d Rsrc=%h exp=%h", n, Rsrc, exp_read(src)); else n_pass++;
         n_checks++; if (Rdst !== exp_read(dst)) $display("FAIL rnd_rdst n=%0d Rdst=%h exp=%h", n, Rdst, exp_read(dst)); else n_pass++;
         n_checks++; if (stall !== exp_stall()) $display("FAIL rnd_stall n=%0d stall=%b exp=%b", n, stall, exp_stall()); else n_pass++;
         n_checks++; if (clr_busy !== m_busy) $display("FAIL rnd_busy n=%0d clr_busy=%b exp=%b", n, clr_busy, m_busy); else n_pass++;
         step();
      end
      idle_inputs();
      for (int n = 0; n < 40 && m_busy; n++) step();
   endtask

   task automatic test_param_sweep();
      int busy_cycles;
      w_WE = 1; w_WA = 5'd31; w_WD = 32'hDEADBEEF; w_src = 5'd31; w_dst = 5'd30;
      step();
      w_WE = 0;
      #1;
      n_checks++; if (w_Rsrc !== 32'hDEADBEEF) $display("FAIL wide_read Rsrc=%h exp=%h", w_Rsrc, 32'hDEADBEEF); else n_pass++;
      n_checks++; if (w_Rdst !== 32'h0) $display("FAIL wide_other Rdst=%h exp=0", w_Rdst); else n_pass++;
      w_clr_req = 1;
      step();
      w_clr_req = 0;
      busy_cycles = 0;
      while (w_clr_busy === 1'b1 && busy_cycles < 100) begin
         step();
         busy_cycles++;
      end
      n_checks++; if (busy_cycles != 32) $display("FAIL wide_clear_len cycles=%0d exp=32", busy_cycles); else n_pass++;
      n_checks++; if (w_Rsrc !== 32'h0) $display("FAIL wide_cleared Rsrc=%h exp=0", w_Rsrc); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_scoreboard();
      test_clear();
      test_reset_mid_clear();
      test_zero_reg();
      test_random();
      test_param_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised next-generation general-purpose register file for the processor datapath.
- Provides two asynchronous read ports, one synchronous write port, and same-cycle write-to-read forwarding.
- Includes a pending-write scoreboard that raises a stall for hazards.
- Includes a clear sequencer that zeroes the array one entry per cycle on request.
- Sits between decode (read addresses, scoreboard marks) and writeback (write port).

Parameters:
- DATA_W, 16, width of each register and of all data ports.
- ADDR_W, 4, register address width.
- NREGS = 2**ADDR_W is a derived localparam, not overridable.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- src  in  ADDR_W  read address, port A
- dst  in  ADDR_W  read address, port B
- Rsrc  out  DATA_W  read data, port A
- Rdst  out  DATA_W  read data, port B
- WE  in  1  write enable
- WA  in  ADDR_W  write address
- WD  in  DATA_W  write data
- mark  in  1  set pending bit for mark_addr (instruction issued with outstanding result)
- mark_addr  in  ADDR_W  register to mark pending
- stall  out  1  pending[src] | pending[dst]
- clr_req  in  1  start clear sequence (level sampled in IDLE)
- clr_busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst=1, asynchronous):
  - all NREGS registers = 0; pending[NREGS-1:0] = 0; FSM = IDLE; clear counter = 0.
  - Outputs during reset: clr_busy=0, stall=0, Rsrc=Rdst=0 (unless forwarding applies).
  - Deassertion is synchronous to clk only by system convention; the block needs no synchronizer.
- Reads: combinational, zero latency.
  - Rsrc = (WE_eff && WA==src) ? WD : reg[src]. Rdst is defined the same way with dst.
  - WE_eff = WE && state==IDLE.
- Write: on the rising edge with WE_eff=1, reg[WA] <= WD. The new value is visible through the array from the next cycle and through forwarding in the same cycle.
- Scoreboard, per cycle in IDLE:
  - WE_eff clears pending[WA].
  - mark sets pending[mark_addr].
  - If mark and WE_eff target the same address in the same cycle, mark wins and the bit ends at 1 (a new writer is outstanding).
  - stall is combinational from the current pending vector. Same-cycle forwarding does not suppress stall; the bit clears on the edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1 at the edge. Counter loads 0; clr_busy=1 from the next cycle.
  - In CLEAR, each edge writes reg[cnt] <= 0 and pending[cnt] <= 0, then cnt increments.
  - After the edge that writes cnt==NREGS-1, return to IDLE and clear clr_busy. Total is exactly NREGS busy cycles.
  - During CLEAR: WE and mark are ignored (dropped, not queued); clr_req is ignored; reads return current array contents (partly cleared); forwarding is disabled.
  - stall during CLEAR is forced to 1 so the pipeline holds.
  - rst asserted mid-CLEAR aborts immediately to the reset state.
- Counter wrap: cnt is ADDR_W bits and is never compared past NREGS-1.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined:
  - Register 0 is hardwired to zero: reads of address 0 return 0, including when forwarding would apply.
  - Writes to 0 are discarded.
  - mark to 0 never sets pending[0], so stall is never raised by address 0.
  - The clear sequencer still visits address 0 (no-op).
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - FSM state encoding typedef (IDLE=1'b0, CLEAR=1'b1).
- One natural sub-module: regfile_scoreboard. It holds the pending vector, the mark/clear priority, and the stall generation, with inputs from the write port, mark port and clear counter.
- The storage array, forwarding and clear FSM stay in regfile_sb.

Test Plan:
- Reset, then write/read:
  - Assert rst; write WE=1, WA=3, WD=16'h00A5.
  - The same cycle with src=3 gives Rsrc=16'h00A5 (forward).
  - The next cycle with WE=0 gives Rsrc=16'h00A5 (array); Rdst with dst=4 reads 0.
- Scoreboard:
  - mark=1, mark_addr=5, then src=5 gives stall=1.
  - Write WA=5 gives stall=0 the following cycle.
  - Same-cycle mark=1/mark_addr=7 and WE=1/WA=7 leave pending[7]=1 (stall with src=7).
- Clear sequence:
  - Fill regs 0..15 with value index+1 and mark reg 9; pulse clr_req.
  - clr_busy is high for exactly 16 cycles and stall=1 throughout.
  - A WE=1, WA=2, WD=16'hFFFF issued mid-clear is dropped.
  - Afterwards all regs read 0 and stall=0.
- Reset mid-clear:
  - Assert rst at clear cycle 6.
  - clr_busy drops asynchronously; all regs read 0; FSM is IDLE and accepts a write next cycle.
- REGFILE_ZERO_REG_EN:
  - Write WA=0, WD=16'h1234 with src=0; Rsrc=0 in the same and the next cycle.
  - mark_addr=0 gives stall=0.
  - Without the macro, Rsrc=16'h1234.
- Parameter sweep:
  - DATA_W=32, ADDR_W=5: write WA=31, WD=32'hDEADBEEF and read it back.
  - The clear sequence takes 32 cycles.
